// File: rtl/fpnew_inorder_retire_ctrl.sv
// In-order retirement controller for the FPU opgroup blocks.
// An ordering FIFO of group indices decides which group may drive the single result port.
module fpnew_inorder_retire_ctrl #(
    parameter int unsigned NumGroups = 4,
    parameter int unsigned Depth     = 8,
    parameter int unsigned Width     = 64,
    parameter int unsigned TagWidth  = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [$clog2(NumGroups)-1:0]    opgroup_i,
    input  logic                            flush_i,
    output logic [NumGroups-1:0]            grp_in_valid_o,
    input  logic [NumGroups-1:0]            grp_in_ready_i,
    input  logic [NumGroups-1:0]            grp_out_valid_i,
    output logic [NumGroups-1:0]            grp_out_ready_o,
    input  logic [NumGroups*Width-1:0]      grp_result_i,
    input  logic [NumGroups*5-1:0]          grp_status_i,
    input  logic [NumGroups*TagWidth-1:0]   grp_tag_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [Width-1:0]                result_o,
    output logic [4:0]                      status_o,
    output logic [TagWidth-1:0]             tag_o,
    output logic                            busy_o
);

    localparam int unsigned GW = $clog2(NumGroups);
    localparam int unsigned PW = $clog2(Depth);
    localparam int unsigned CW = $clog2(Depth + 1);
    localparam logic [CW-1:0] DepthCnt = CW'(Depth);

    logic [GW-1:0]       fifo_q [Depth];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       cnt_q;
    logic                full, empty, push, pop;
    logic [GW-1:0]       head;

    logic [Width-1:0]    res_arr [NumGroups];
    logic [4:0]          sts_arr [NumGroups];
    logic [TagWidth-1:0] tag_arr [NumGroups];

    for (genvar g = 0; g < NumGroups; g++) begin : g_unpack
        assign res_arr[g] = grp_result_i[g*Width +: Width];
        assign sts_arr[g] = grp_status_i[g*5 +: 5];
        assign tag_arr[g] = grp_tag_i[g*TagWidth +: TagWidth];
    end

    // Full comes from the registered count: a same-cycle pop does not free a slot.
    assign full  = (cnt_q == DepthCnt);
    assign empty = (cnt_q == '0);
    assign head  = fifo_q[rd_ptr_q];
    assign busy_o = !empty;

    always_comb begin
        in_ready_o     = !full && !flush_i && grp_in_ready_i[opgroup_i];
        grp_in_valid_o = '0;
        if (in_valid_i && !full && !flush_i) begin
            grp_in_valid_o[opgroup_i] = 1'b1;
        end
        push = in_valid_i && in_ready_o;
    end

    // Only the head group is released; other finished groups wait with stable data.
    always_comb begin
        out_valid_o     = !empty && !flush_i && grp_out_valid_i[head];
        grp_out_ready_o = '0;
        if (!empty && !flush_i && out_ready_i) begin
            grp_out_ready_o[head] = 1'b1;
        end
        result_o = '0;
        status_o = '0;
        tag_o    = '0;
        if (out_valid_o) begin
            result_o = res_arr[head];
            status_o = sts_arr[head];
            tag_o    = tag_arr[head];
        end
        pop = out_valid_o && out_ready_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < Depth; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= opgroup_i;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fpnew_inorder_retire_ctrl.sv
// Directed bench for fpnew_inorder_retire_ctrl: simple per-group result models
// feed a scoreboard that expects results in issue order.
module tb_fpnew_inorder_retire_ctrl;

    localparam int NG = 4;
    localparam int DP = 8;
    localparam int W  = 64;
    localparam int TW = 1;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [1:0]       opgroup_i;
    logic             flush_i;
    logic [NG-1:0]    grp_in_valid_o;
    logic [NG-1:0]    grp_in_ready_i;
    logic [NG-1:0]    grp_out_valid_i;
    logic [NG-1:0]    grp_out_ready_o;
    logic [NG*W-1:0]  grp_result_i;
    logic [NG*5-1:0]  grp_status_i;
    logic [NG*TW-1:0] grp_tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [W-1:0]     result_o;
    logic [4:0]       status_o;
    logic [TW-1:0]    tag_o;
    logic             busy_o;

    fpnew_inorder_retire_ctrl #(.NumGroups(NG), .Depth(DP), .Width(W), .TagWidth(TW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .opgroup_i(opgroup_i), .flush_i(flush_i), .grp_in_valid_o(grp_in_valid_o),
        .grp_in_ready_i(grp_in_ready_i), .grp_out_valid_i(grp_out_valid_i),
        .grp_out_ready_o(grp_out_ready_o), .grp_result_i(grp_result_i),
        .grp_status_i(grp_status_i), .grp_tag_i(grp_tag_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .result_o(result_o), .status_o(status_o), .tag_o(tag_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0]  grp;
        logic [15:0] seq;
    } sb_t;

    sb_t         sb[$];
    int unsigned gq[NG][$];
    logic [NG-1:0] grp_en;
    int          n_err = 0;
    int          n_chk = 0;
    int unsigned next_seq = 0;
    logic        exp_push, exp_pop, exp_ovalid;

    function automatic logic [W-1:0] res_of(input int unsigned s);
        return {48'hFACECAFE0000, s[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        for (int g = 0; g < NG; g++) gq[g].delete();
    endtask

    // Drive group outputs from the per-group models, let logic settle, check
    // handshake outputs against the scoreboard view of occupancy.
    task automatic settle();
        for (int g = 0; g < NG; g++) begin
            if (grp_en[g] && gq[g].size() > 0) begin
                grp_out_valid_i[g]        = 1'b1;
                grp_result_i[g*W +: W]    = res_of(gq[g][0]);
                grp_status_i[g*5 +: 5]    = 5'(gq[g][0]);
                grp_tag_i[g*TW +: TW]     = TW'(gq[g][0]);
            end else begin
                grp_out_valid_i[g]        = 1'b0;
                grp_result_i[g*W +: W]    = '0;
                grp_status_i[g*5 +: 5]    = '0;
                grp_tag_i[g*TW +: TW]     = '0;
            end
        end
        #1;
        exp_push   = in_valid_i && (sb.size() < DP) && !flush_i && grp_in_ready_i[opgroup_i];
        exp_ovalid = (sb.size() > 0) && !flush_i && grp_out_valid_i[sb[0].grp];
        exp_pop    = exp_ovalid && out_ready_i;
        chk("in_ready", 64'(in_ready_o), 64'(exp_push || (!in_valid_i && (sb.size() < DP)
                                               && !flush_i && grp_in_ready_i[opgroup_i])));
        chk("out_valid", 64'(out_valid_o), 64'(exp_ovalid));
        chk("busy", 64'(busy_o), 64'(sb.size() > 0));
    endtask

    task automatic finish_cycle();
        if (exp_pop) begin
            chk("result", result_o, res_of(sb[0].seq));
            chk("tag", 64'(tag_o), 64'(sb[0].seq[0]));
            chk("status", 64'(status_o), 64'(sb[0].seq[4:0]));
            void'(gq[sb[0].grp].pop_front());
            void'(sb.pop_front());
        end
        if (exp_push) begin
            sb.push_back('{grp: opgroup_i, seq: 16'(next_seq)});
            gq[opgroup_i].push_back(next_seq);
            next_seq++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic cycle();
        settle();
        finish_cycle();
    endtask

    task automatic issue(input logic [1:0] g);
        in_valid_i = 1'b1;
        opgroup_i  = g;
        cycle();
        in_valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        grp_en = '1;
        for (int k = 0; k < 40 && sb.size() > 0; k++) cycle();
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni = 1'b0; in_valid_i = 1'b0; opgroup_i = '0; flush_i = 1'b0;
        grp_in_ready_i = '1; out_ready_i = 1'b1; grp_en = '0;
        grp_out_valid_i = '0; grp_result_i = '0; grp_status_i = '0; grp_tag_i = '0;

        // Reset state
        #2;
        chk("rst_in_ready_grp_rdy", 64'(in_ready_o), 64'd1);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_grp_out_ready", 64'(grp_out_ready_o), 64'd0);
        chk("rst_grp_in_valid", 64'(grp_in_valid_o), 64'd0);
        grp_in_ready_i = '0;
        #1;
        chk("rst_in_ready_grp_busy", 64'(in_ready_o), 64'd0);
        grp_in_ready_i = '1;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Out-of-order completion: g1 then g0, g0 finishes first and must wait
        issue(2'd1);
        issue(2'd0);
        grp_en[0] = 1'b1;
        repeat (3) begin
            settle();
            chk("stall_g0_ready", 64'(grp_out_ready_o), 64'(4'b0010));
            finish_cycle();
        end
        grp_en[1] = 1'b1;
        settle();
        chk("order_first_g1", 64'(result_o), 64'(res_of(0)));
        finish_cycle();
        drain("order_drain");

        // Fill to Depth, then pop with a simultaneous refused push
        grp_en = '0;
        for (int i = 0; i < DP; i++) issue(2'(i % NG));
        in_valid_i = 1'b1; opgroup_i = 2'd1;
        settle();
        chk("full_in_ready", 64'(in_ready_o), 64'd0);
        chk("full_grp_in_valid", 64'(grp_in_valid_o), 64'd0);
        finish_cycle();
        grp_en[0] = 1'b1;
        settle();
        chk("full_pop_valid", 64'(out_valid_o), 64'd1);
        chk("full_pop_no_push", 64'(in_ready_o), 64'd0);
        finish_cycle();
        grp_en = '0;
        in_valid_i = 1'b0;
        settle();
        chk("after_pop_in_ready", 64'(in_ready_o), 64'd1);
        chk("after_pop_cnt7", 64'(sb.size()), 64'd7);
        finish_cycle();
        drain("full_drain");

        // Streaming issue/retire, pointers wrap several times
        grp_en = '1; out_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid_i = 1'b1;
            opgroup_i  = 2'((i * 3) % NG);
            cycle();
        end
        drain("stream_drain");

        // Downstream back-pressure holds head data
        issue(2'd2);
        grp_en = '1; out_ready_i = 1'b0;
        repeat (3) begin
            settle();
            chk("bp_grp_out_ready", 64'(grp_out_ready_o), 64'd0);
            chk("bp_result_stable", result_o, res_of(sb[0].seq));
            chk("bp_tag_stable", 64'(tag_o), 64'(sb[0].seq[0]));
            finish_cycle();
        end
        drain("bp_drain");

        // Flush with five in flight
        grp_en = '0;
        for (int i = 0; i < 5; i++) issue(2'(i % NG));
        in_valid_i = 1'b1; opgroup_i = 2'd3; flush_i = 1'b1; grp_en = '1;
        settle();
        chk("flush_grp_in_valid", 64'(grp_in_valid_o), 64'd0);
        chk("flush_grp_out_ready", 64'(grp_out_ready_o), 64'd0);
        finish_cycle();
        clear_model();
        flush_i = 1'b0; in_valid_i = 1'b0;
        settle();
        chk("post_flush_busy", 64'(busy_o), 64'd0);
        finish_cycle();
        issue(2'd2);
        drain("post_flush_drain");

        // Target group not ready: no push
        grp_en = '0;
        grp_in_ready_i = 4'b1101; in_valid_i = 1'b1; opgroup_i = 2'd1;
        settle();
        chk("gnr_in_ready", 64'(in_ready_o), 64'd0);
        chk("gnr_grp_in_valid", 64'(grp_in_valid_o), 64'(4'b0010));
        finish_cycle();
        in_valid_i = 1'b0; grp_in_ready_i = '1;
        settle();
        chk("gnr_no_push", 64'(busy_o), 64'd0);
        finish_cycle();

        // Reset mid-operation with three in flight
        for (int i = 0; i < 3; i++) issue(2'(i + 1));
        grp_en = '1; out_ready_i = 1'b1; grp_in_ready_i = '0;
        settle();
        rst_ni = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid_o), 64'd0);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_result", result_o, 64'd0);
        chk("midrst_tag", 64'(tag_o), 64'd0);
        chk("midrst_grp_out_ready", 64'(grp_out_ready_o), 64'd0);
        chk("midrst_in_ready", 64'(in_ready_o), 64'd0);
        clear_model();
        @(posedge clk_i); #1;
        rst_ni = 1'b1; grp_in_ready_i = '1;
        issue(2'd3);
        drain("post_rst_drain");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
